// File: rtl/if_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : if_fetch_unit
// Description : Instruction fetch producer for the rv32im pipelined core.
//               Owns the architectural fetch PC, issues word requests to the
//               instruction memory over a req/busywait handshake, buffers up
//               to two returned instructions in a small FIFO and presents the
//               head (instruction + PC) to the IF/ID stage register. Honours
//               decode stall and branch/jump redirect (flush).
// Options     : `define IF_FETCH_PERF_CNT_EN adds fetch_cnt_o / bubble_cnt_o
//               performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  // instruction memory side
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_rdata_i,
  input  logic        imem_busywait_i,
  // pipeline control
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  // IF/ID side
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
`ifdef IF_FETCH_PERF_CNT_EN
  output logic [31:0] fetch_cnt_o,
  output logic [31:0] bubble_cnt_o,
`endif
  output logic        busywait_o
);

  // FETCH : request outstanding at the fetch PC
  // HOLD  : buffer full, no request issued
  // DRAIN : finishing a request that a redirect made stale
  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_HOLD  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  state_e      r_state;
  state_e      w_state_nxt;

  logic [31:0] r_fetch_pc;
  logic [31:0] w_fetch_pc_nxt;
  logic [31:0] r_target;
  logic [31:0] w_target_nxt;

  // Two-entry buffer kept as a shift register: entry 0 is always the head.
  logic [1:0]  r_count;
  logic [1:0]  w_count_nxt;
  logic [31:0] r_b0_instr;
  logic [31:0] r_b0_pc;
  logic [31:0] r_b1_instr;
  logic [31:0] r_b1_pc;
  logic [31:0] w_b0_instr_nxt;
  logic [31:0] w_b0_pc_nxt;
  logic [31:0] w_b1_instr_nxt;
  logic [31:0] w_b1_pc_nxt;

  logic        w_xfer_done;
  logic        w_head_valid;
  logic        w_consume;
  logic        w_push;
  logic [31:0] w_redirect_pc;

  // The request is gated by rst_ni so it is low for the whole reset window,
  // not only after the first clock edge.
  assign imem_req_o    = rst_ni & ((r_state == ST_FETCH) | (r_state == ST_DRAIN));
  // In DRAIN the fetch PC still holds the stale address, keeping addr stable.
  assign imem_addr_o   = r_fetch_pc;

  assign w_xfer_done   = imem_req_o & ~imem_busywait_i;
  assign w_head_valid  = (r_count != 2'd0);
  assign w_redirect_pc = {redirect_pc_i[31:2], 2'b00};

  // A redirect flushes the buffer, so it wins over both consume and push.
  assign w_consume     = w_head_valid & ~stall_i & ~redirect_i;
  // Responses completing in DRAIN belong to the abandoned path.
  assign w_push        = w_xfer_done & (r_state == ST_FETCH) & ~redirect_i;

  assign instr_o       = w_head_valid ? r_b0_instr : NOP_INSTR;
  assign pc_o          = w_head_valid ? r_b0_pc    : 32'h0000_0000;
  assign busywait_o    = ~w_head_valid;

  // Buffer next-state: flush, push, pop or simultaneous push/pop.
  always_comb begin
    w_count_nxt    = r_count;
    w_b0_instr_nxt = r_b0_instr;
    w_b0_pc_nxt    = r_b0_pc;
    w_b1_instr_nxt = r_b1_instr;
    w_b1_pc_nxt    = r_b1_pc;
    if (redirect_i) begin
      w_count_nxt = 2'd0;
    end else begin
      case ({w_push, w_consume})
        2'b10: begin
          if (r_count == 2'd0) begin
            w_b0_instr_nxt = imem_rdata_i;
            w_b0_pc_nxt    = r_fetch_pc;
          end else begin
            w_b1_instr_nxt = imem_rdata_i;
            w_b1_pc_nxt    = r_fetch_pc;
          end
          w_count_nxt = r_count + 2'd1;
        end
        2'b01: begin
          w_b0_instr_nxt = r_b1_instr;
          w_b0_pc_nxt    = r_b1_pc;
          w_count_nxt    = r_count - 2'd1;
        end
        2'b11: begin
          // Occupancy is unchanged; the new word lands behind whatever remains.
          if (r_count == 2'd1) begin
            w_b0_instr_nxt = imem_rdata_i;
            w_b0_pc_nxt    = r_fetch_pc;
          end else begin
            w_b0_instr_nxt = r_b1_instr;
            w_b0_pc_nxt    = r_b1_pc;
            w_b1_instr_nxt = imem_rdata_i;
            w_b1_pc_nxt    = r_fetch_pc;
          end
        end
        default: begin
          w_count_nxt = r_count;
        end
      endcase
    end
  end

  // Buffer storage registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_count    <= 2'd0;
      r_b0_instr <= NOP_INSTR;
      r_b0_pc    <= 32'h0000_0000;
      r_b1_instr <= NOP_INSTR;
      r_b1_pc    <= 32'h0000_0000;
    end else begin
      r_count    <= w_count_nxt;
      r_b0_instr <= w_b0_instr_nxt;
      r_b0_pc    <= w_b0_pc_nxt;
      r_b1_instr <= w_b1_instr_nxt;
      r_b1_pc    <= w_b1_pc_nxt;
    end
  end

  // Fetch FSM next-state, fetch-PC and saved-target logic.
  always_comb begin
    w_state_nxt    = r_state;
    w_fetch_pc_nxt = r_fetch_pc;
    w_target_nxt   = r_target;
    case (r_state)
      ST_FETCH: begin
        if (redirect_i) begin
          if (w_xfer_done) begin
            // Returned word is dropped; restart straight at the target.
            w_fetch_pc_nxt = w_redirect_pc;
          end else begin
            // Cannot retract a pending request: finish it, then jump.
            w_target_nxt = w_redirect_pc;
            w_state_nxt  = ST_DRAIN;
          end
        end else if (w_xfer_done) begin
          w_fetch_pc_nxt = r_fetch_pc + 32'd4;
          if (w_count_nxt == 2'd2) begin
            w_state_nxt = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (redirect_i) begin
          w_fetch_pc_nxt = w_redirect_pc;
          w_state_nxt    = ST_FETCH;
        end else if (w_count_nxt != 2'd2) begin
          w_state_nxt = ST_FETCH;
        end
      end
      ST_DRAIN: begin
        // The newest redirect always replaces the saved target.
        if (redirect_i) begin
          w_target_nxt = w_redirect_pc;
        end
        if (w_xfer_done) begin
          w_fetch_pc_nxt = redirect_i ? w_redirect_pc : r_target;
          w_state_nxt    = ST_FETCH;
        end
      end
      default: begin
        w_state_nxt = ST_FETCH;
      end
    endcase
  end

  // Fetch FSM state, fetch PC and saved redirect target registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= ST_FETCH;
      r_fetch_pc <= RESET_PC;
      r_target   <= RESET_PC;
    end else begin
      r_state    <= w_state_nxt;
      r_fetch_pc <= w_fetch_pc_nxt;
      r_target   <= w_target_nxt;
    end
  end

`ifdef IF_FETCH_PERF_CNT_EN
  logic [31:0] r_fetch_cnt;
  logic [31:0] r_bubble_cnt;

  // Consumed-instruction and bubble-cycle counters; free-running, wrap at 2^32.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_fetch_cnt  <= 32'h0000_0000;
      r_bubble_cnt <= 32'h0000_0000;
    end else begin
      if (w_consume) begin
        r_fetch_cnt <= r_fetch_cnt + 32'd1;
      end
      if (!w_head_valid) begin
        r_bubble_cnt <= r_bubble_cnt + 32'd1;
      end
    end
  end

  assign fetch_cnt_o  = r_fetch_cnt;
  assign bubble_cnt_o = r_bubble_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_fetch_unit
// Description : Self-checking bench for if_fetch_unit. A transaction-level
//               reference model tracks the architectural fetch stream (next
//               fetch address, buffered PCs, abandoned transactions) and a
//               memory model answers requests with programmable latency.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_rdata_i;
  logic        imem_busywait_i;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic        busywait_o;
`ifdef IF_FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_o;
  logic [31:0] bubble_cnt_o;
`endif

  if_fetch_unit dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .imem_req_o      (imem_req_o),
    .imem_addr_o     (imem_addr_o),
    .imem_rdata_i    (imem_rdata_i),
    .imem_busywait_i (imem_busywait_i),
    .stall_i         (stall_i),
    .redirect_i      (redirect_i),
    .redirect_pc_i   (redirect_pc_i),
    .instr_o         (instr_o),
    .pc_o            (pc_o),
`ifdef IF_FETCH_PERF_CNT_EN
    .fetch_cnt_o     (fetch_cnt_o),
    .bubble_cnt_o    (bubble_cnt_o),
`endif
    .busywait_o      (busywait_o)
  );

  always #5 clk_i = ~clk_i;

  int checks   = 0;
  int failures = 0;

  // Memory model state
  bit          rand_lat;
  logic [31:0] slow_addr;
  int          slow_cycles;
  bit          in_txn;
  int          wait_left;

  // Reference model state
  logic [31:0] q_pc[$];
  logic [31:0] exp_fetch;
  bit          discard_next;
  bit          prev_rb;
  logic [31:0] prev_addr;
  logic [31:0] m_fetch_cnt;
  logic [31:0] m_bubble_cnt;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h0019_660D) ^ 32'hC3A5_1E0F;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One clock: check outputs against model, drive inputs, advance model, clock.
  task automatic step(input bit stall, input bit redir, input logic [31:0] tgt);
    bit          busy;
    bit          done;
    bit          req;
    logic [31:0] addr;
    req  = imem_req_o;
    addr = imem_addr_o;

    chk("bw_o", {31'd0, busywait_o}, {31'd0, (q_pc.size() == 0)});
    if (q_pc.size() != 0) begin
      chk("head_pc", pc_o, q_pc[0]);
      chk("head_instr", instr_o, mem_word(q_pc[0]));
    end else begin
      chk("empty_pc", pc_o, 32'h0);
      chk("empty_instr", instr_o, NOP);
    end
    chk("req", {31'd0, req}, {31'd0, (q_pc.size() < 2)});
    if (prev_rb) begin
      chk("req_hold", {31'd0, req}, 32'd1);
      chk("addr_hold", addr, prev_addr);
    end
    if (req) chk("addr_align", {30'd0, addr[1:0]}, 32'd0);
`ifdef IF_FETCH_PERF_CNT_EN
    chk("fetch_cnt", fetch_cnt_o, m_fetch_cnt);
    chk("bubble_cnt", bubble_cnt_o, m_bubble_cnt);
`endif

    // memory response
    if (req) begin
      if (!in_txn) begin
        in_txn    = 1'b1;
        wait_left = rand_lat ? int'($urandom_range(0, 3)) :
                    ((addr == slow_addr) ? slow_cycles : 0);
      end
      busy = (wait_left != 0);
      if (busy) wait_left--;
      else in_txn = 1'b0;
    end else begin
      busy = 1'($urandom_range(0, 1));
    end
    imem_busywait_i = busy;
    imem_rdata_i    = (req && !busy) ? mem_word(addr) : $urandom;
    stall_i         = stall;
    redirect_i      = redir;
    redirect_pc_i   = tgt;

    // model update for the coming edge
    done = req && !busy;
    if (q_pc.size() == 0) m_bubble_cnt = m_bubble_cnt + 32'd1;
    if (redir) begin
      q_pc.delete();
      exp_fetch    = {tgt[31:2], 2'b00};
      discard_next = (req && busy);
    end else begin
      if (q_pc.size() != 0 && !stall) begin
        void'(q_pc.pop_front());
        m_fetch_cnt = m_fetch_cnt + 32'd1;
      end
      if (done) begin
        if (discard_next) begin
          discard_next = 1'b0;
        end else begin
          chk("fetch_addr", addr, exp_fetch);
          q_pc.push_back(addr);
          exp_fetch = exp_fetch + 32'd4;
        end
      end
    end
    prev_rb   = req && busy;
    prev_addr = addr;

    @(posedge clk_i);
    @(negedge clk_i);
    #1;
  endtask

  task automatic reset_dut();
    rst_ni          = 1'b0;
    stall_i         = 1'b0;
    redirect_i      = 1'b0;
    redirect_pc_i   = 32'h0;
    imem_busywait_i = 1'b0;
    imem_rdata_i    = 32'h0;
    q_pc.delete();
    exp_fetch    = 32'h0;
    discard_next = 1'b0;
    prev_rb      = 1'b0;
    prev_addr    = 32'h0;
    in_txn       = 1'b0;
    wait_left    = 0;
    m_fetch_cnt  = 32'h0;
    m_bubble_cnt = 32'h0;
    @(negedge clk_i);
    @(negedge clk_i);
    #1;
    chk("rst_req", {31'd0, imem_req_o}, 32'd0);
    chk("rst_bw", {31'd0, busywait_o}, 32'd1);
    chk("rst_instr", instr_o, NOP);
    chk("rst_pc", pc_o, 32'h0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    #1;
  endtask

  initial begin
    int          seen;
    bit          found;
    logic [31:0] frozen;

    rand_lat    = 1'b0;
    slow_addr   = 32'h1;
    slow_cycles = 0;

    // Reset release, zero-wait, no stall: one word per cycle.
    reset_dut();
    chk("t1_addr0", imem_addr_o, 32'h0);
    chk("t1_req0", {31'd0, imem_req_o}, 32'd1);
    step(0, 0, 0);
    chk("t1_addr1", imem_addr_o, 32'h4);
    chk("t1_pc0", pc_o, 32'h0);
    chk("t1_bw_low", {31'd0, busywait_o}, 32'd0);
    step(0, 0, 0);
    chk("t1_addr2", imem_addr_o, 32'h8);
    chk("t1_pc1", pc_o, 32'h4);
    step(0, 0, 0);
    chk("t1_pc2", pc_o, 32'h8);

    // Three wait cycles on 0x4: address stable over four request cycles.
    slow_addr   = 32'h4;
    slow_cycles = 3;
    reset_dut();
    step(0, 0, 0);
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      chk("t2_addr", imem_addr_o, 32'h4);
      chk("t2_req", {31'd0, imem_req_o}, 32'd1);
      step(0, 0, 0);
    end
    for (int i = 0; i < 6; i++) begin
      if (!busywait_o && pc_o == 32'h4) seen++;
      step(0, 0, 0);
    end
    chk("t2_once", seen, 1);
    slow_addr = 32'h1;

    // Stall four cycles: buffer fills, request drops, head frozen.
    step(1, 0, 0);
    frozen = instr_o;
    step(1, 0, 0);
    step(1, 0, 0);
    step(1, 0, 0);
    chk("t3_hold_req", {31'd0, imem_req_o}, 32'd0);
    chk("t3_frozen", instr_o, frozen);
    for (int i = 0; i < 6; i++) step(0, 0, 0);

    // Redirect while fetch of 0x8 is pending: stale word dropped.
    slow_addr   = 32'h8;
    slow_cycles = 3;
    reset_dut();
    step(0, 0, 0);
    step(0, 0, 0);
    chk("t4_addr8", imem_addr_o, 32'h8);
    step(0, 1, 32'h0000_1002);
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      if (imem_addr_o != 32'h8) found = 1'b1;
      else step(0, 0, 0);
    end
    chk("t4_drain_done", {31'd0, found}, 32'd1);
    chk("t4_addr_tgt", imem_addr_o, 32'h0000_1000);
    step(0, 0, 0);
    chk("t4_pc_tgt", pc_o, 32'h0000_1000);
    slow_addr = 32'h1;

    // Fetch PC wrap-around.
    step(0, 1, 32'hFFFF_FFFA);
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      if (imem_req_o && imem_addr_o == 32'h0) found = 1'b1;
      else step(0, 0, 0);
    end
    chk("t5_wrap", {31'd0, found}, 32'd1);
    for (int i = 0; i < 4; i++) step(0, 0, 0);

    // Randomized traffic: latency, stalls and redirects.
    rand_lat = 1'b1;
    reset_dut();
    for (int i = 0; i < 2000; i++) begin
      step(($urandom_range(0, 99) < 30), ($urandom_range(0, 99) < 5), $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction fetch producer for the rv32im pipelined core.
- Owns the architectural fetch PC and issues word requests to the instruction memory/cache over a req/busywait handshake.
- Buffers up to two returned instructions and presents them, with their PC, to the IF/ID stage register.
- Drives that register's busywait; obeys decode stall and branch/jump redirect (flush).

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- NOP_INSTR, 32'h0000_0013, value driven on instr_o when no valid instruction (addi x0,x0,0).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- imem_req_o  out  1  fetch request.
- imem_addr_o  out  32  word address; [1:0] always 0.
- imem_rdata_i  in  32  instruction, valid in the completing cycle.
- imem_busywait_i  in  1  high = request not yet complete.
- stall_i  in  1  IF/ID stall (hazard unit).
- redirect_i  in  1  taken branch/jump; flush.
- redirect_pc_i  in  32  redirect target; [1:0] ignored.
- instr_o  out  32  instruction to IF/ID.
- pc_o  out  32  PC of instr_o.
- busywait_o  out  1  to IF/ID busywait; equals !valid of buffer head.

Behaviour:
- Reset: asynchronous, active-low, one clock; fixed polarity and synchronicity.
- Reset values: fetch PC = RESET_PC; state FETCH; buffer empty; instr_o = NOP_INSTR; pc_o = 0; busywait_o = 1; imem_req_o = 0 while rst_ni low.
- Reset mid-transaction: the in-flight request is abandoned; memory is reset on the same rst_ni.
- Handshake: a transfer completes on a rising edge where imem_req_o=1 and imem_busywait_i=0. imem_addr_o holds stable from assertion to completion, and req never drops before completion. Minimum latency is 1 cycle (busywait low in the first req cycle).
- 2-entry FIFO: head drives instr_o/pc_o; empty head drives NOP_INSTR/0.
  - Head is consumed at an edge with head valid and stall_i=0.
  - Simultaneous completion and consume: occupancy unchanged.
  - Steady state, no stall, zero-wait memory: one instruction per cycle.
- PC arithmetic: fetch PC += 4 on every completion, modulo 2^32 (0xFFFF_FFFC wraps to 0x0000_0000).
- States:
  - FETCH: req=1, addr=fetch PC. Completion with post-edge occupancy 2 -> HOLD.
  - HOLD: req=0. Leave to FETCH at the edge where occupancy drops below 2.
  - DRAIN: req=1 at the old address until completion. The response is discarded; fetch PC = saved target; then FETCH.
- Redirect (priority over stall and consume):
  - FIFO flushed at that edge; next cycle busywait_o=1, instr_o=NOP_INSTR.
  - Target = {redirect_pc_i[31:2],2'b00}.
  - From FETCH with busywait=1 (not completing): save target -> DRAIN.
  - From FETCH completing that edge: data discarded, fetch PC = target, stay FETCH.
  - From HOLD: fetch PC = target -> FETCH.
  - In DRAIN: saved target overwritten with the newest redirect.
- Stall with empty FIFO: no effect on fetching.

Optional Feature:
- Macro: IF_FETCH_PERF_CNT_EN.
- Defined:
  - Adds outputs fetch_cnt_o[31:0] (instructions consumed by IF/ID) and bubble_cnt_o[31:0] (cycles with busywait_o=1 and rst_ni high).
  - Both counters reset to 0, wrap at 2^32, and are not cleared by redirect.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset release, zero-wait memory, stall=0 -> addresses 0x0,0x4,0x8 on consecutive cycles; pc_o 0x0,0x4,0x8 one cycle later; busywait_o low from 2nd cycle.
- Memory busywait held 3 cycles on addr 0x4 -> addr stable 0x4 across all 4 req cycles; pc_o=0x4 appears exactly once.
- stall_i held 4 cycles with zero-wait memory -> two completions buffered, req drops (HOLD), instr_o frozen; after release, pc_o sequence is contiguous with no loss or duplicate.
- redirect_i to 0x1002 while fetch of 0x8 pending (busywait=1) -> DRAIN, 0x8 data never appears, next req addr=0x1000, pc_o=0x1000 follows.
- Fetch PC 0xFFFF_FFFC completes -> next req addr 0x0000_0000.
- With IF_FETCH_PERF_CNT_EN: 10 consumes, 3 stall-free bubbles -> fetch_cnt_o=10, bubble_cnt_o=3 plus reset-release bubble count as specified.
